// File: rtl/ebi_tx_link_sched_if.sv
// Channel-request and link-beat signal bundle around the M1->M2 link scheduler.
// Latency: none, wires only.
// Backpressure: carries ch_ready_o pulses toward the channels and link_ready_i toward the scheduler.
interface ebi_tx_link_sched_if #(
    parameter int CH_NUM    = 10,
    parameter int LINK_W    = 32,
    parameter int MAX_BEATS = 8,
    parameter int BEAT_W    = 4
);
    localparam int MSG_W = MAX_BEATS * LINK_W;

    logic [CH_NUM-1:0]        ch_valid_i;
    logic [CH_NUM-1:0]        ch_ready_o;
    logic [CH_NUM*BEAT_W-1:0] ch_beats_i;
    logic [CH_NUM*MSG_W-1:0]  ch_data_i;
    logic                     link_valid_o;
    logic                     link_ready_i;
    logic [LINK_W-1:0]        link_data_o;
    logic [3:0]               link_ch_id_o;
    logic                     link_sof_o;
    logic                     link_eof_o;

    // Scheduler side: takes channel requests, drives the link.
    modport master (
        input  ch_valid_i, ch_beats_i, ch_data_i, link_ready_i,
        output ch_ready_o, link_valid_o, link_data_o, link_ch_id_o, link_sof_o, link_eof_o
    );

    // Environment side: channel handshake registers plus link serdes.
    modport slave (
        output ch_valid_i, ch_beats_i, ch_data_i, link_ready_i,
        input  ch_ready_o, link_valid_o, link_data_o, link_ch_id_o, link_sof_o, link_eof_o
    );
endinterface

// File: rtl/ebi_tx_link_sched.sv
// Arbitrates EBI channel messages (credit channels first, starvation-guarded) and serialises them onto the link.
// Latency: first beat appears the cycle after the accept; back-to-back messages with no bubble.
// Backpressure: link outputs hold while link_ready_i is low; no new accept until the last beat handshakes.
module ebi_tx_link_sched #(
    parameter int                CH_NUM       = 10,
    parameter int                LINK_W       = 32,
    parameter int                MAX_BEATS    = 8,
    parameter int                BEAT_W       = 4,
    parameter logic [CH_NUM-1:0] CR_MASK      = 10'b11111_00000,
    parameter int                STARVE_LIMIT = 8
) (
    input  logic                  m1_clk_i,
    input  logic                  rst_i,
    ebi_tx_link_sched_if.master   bus
);
    localparam int MSG_W = MAX_BEATS * LINK_W;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        state_q;
    logic [MSG_W-1:0]  msg_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] last_q;
    logic [3:0]        id_q;
    logic [3:0]        rr_cr_q;
    logic [3:0]        rr_nc_q;
    logic [SC_W-1:0]   starve_q;

    logic [CH_NUM-1:0] cr_req;
    logic [CH_NUM-1:0] nc_req;
    logic [3:0]        pick_cr;
    logic [3:0]        pick_nc;
    logic [3:0]        win;
    logic [3:0]        win_next;
    logic [BEAT_W-1:0] win_beats;
    logic [BEAT_W-1:0] win_last;
    logic              use_nc;
    logic              link_hs;
    logic              eof;
    logic              slot;
    logic              grant;

    // First requester at or after ptr, ascending with wrap; 0 when nothing requests.
    function automatic logic [3:0] rr_pick(input logic [CH_NUM-1:0] req, input logic [3:0] ptr);
        logic [3:0] res;
        int         idx;
        res = '0;
        // Walk offsets from the far end so the smallest offset is written last and wins.
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= CH_NUM) idx = idx - CH_NUM;
            if (req[idx]) res = 4'(idx);
        end
        return res;
    endfunction

    // Accept slot, group arbitration and beat-count clamp for the winner.
    always_comb begin
        cr_req   = bus.ch_valid_i & CR_MASK;
        nc_req   = bus.ch_valid_i & ~CR_MASK;
        pick_cr  = rr_pick(cr_req, rr_cr_q);
        pick_nc  = rr_pick(nc_req, rr_nc_q);
        link_hs  = (state_q == ST_SEND) && bus.link_ready_i;
        eof      = (state_q == ST_SEND) && (beat_q == last_q);
        slot     = (state_q == ST_IDLE) || (link_hs && eof);
        // Flit group wins when the starvation guard trips or no credit channel asks.
        use_nc   = (|nc_req) && ((starve_q == SC_W'(STARVE_LIMIT)) || !(|cr_req));
        win      = use_nc ? pick_nc : pick_cr;
        win_next = (win == 4'(CH_NUM - 1)) ? 4'd0 : win + 4'd1;
        grant    = slot && (|bus.ch_valid_i);
        win_beats = bus.ch_beats_i[win*BEAT_W +: BEAT_W];
        if (win_beats == '0) begin
            win_last = '0;
        end else if (win_beats > BEAT_W'(MAX_BEATS)) begin
            win_last = BEAT_W'(MAX_BEATS - 1);
        end else begin
            win_last = win_beats - BEAT_W'(1);
        end
        bus.ch_ready_o = grant ? (CH_NUM'(1) << win) : '0;
    end

    // Message register, beat counter and state advance on accept / beat handshake.
    always_ff @(posedge m1_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            msg_q   <= '0;
            beat_q  <= '0;
            last_q  <= '0;
            id_q    <= '0;
        end else if (slot) begin
            state_q <= grant ? ST_SEND : ST_IDLE;
            if (grant) begin
                msg_q  <= bus.ch_data_i[win*MSG_W +: MSG_W];
                beat_q <= '0;
                last_q <= win_last;
                id_q   <= win;
            end
        end else if (link_hs) begin
            beat_q <= beat_q + BEAT_W'(1);
        end
    end

    // Round-robin pointers and the credit-over-flit starvation counter.
    always_ff @(posedge m1_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_cr_q  <= '0;
            rr_nc_q  <= '0;
            starve_q <= '0;
        end else if (grant) begin
            if (use_nc) begin
                rr_nc_q  <= win_next;
                starve_q <= '0;
            end else begin
                rr_cr_q <= win_next;
                if ((|nc_req) && (starve_q != SC_W'(STARVE_LIMIT))) begin
                    starve_q <= starve_q + SC_W'(1);
                end
            end
        end
    end

    // Link outputs come straight from registered state so reset drops them at once.
    always_comb begin
        bus.link_valid_o = (state_q == ST_SEND);
        bus.link_data_o  = msg_q[beat_q*LINK_W +: LINK_W];
        bus.link_ch_id_o = id_q;
        bus.link_sof_o   = (state_q == ST_SEND) && (beat_q == '0);
        bus.link_eof_o   = eof;
    end
endmodule

// File: tb/tb_ebi_tx_link_sched.sv
// Scoreboard bench for the link scheduler: expected grants queued per test, beats checked as they leave.
// Latency: checks first beat one cycle after accept and zero-bubble back-to-back.
// Backpressure: exercises link_ready_i stalls mid-message.
module tb_ebi_tx_link_sched;
    localparam int CH_NUM    = 10;
    localparam int LINK_W    = 32;
    localparam int MAX_BEATS = 8;
    localparam int BEAT_W    = 4;
    localparam int MSG_W     = MAX_BEATS * LINK_W;

    typedef struct {
        logic [LINK_W-1:0] data;
        logic [3:0]        id;
        logic              sof;
        logic              eof;
    } beat_t;

    logic m1_clk;
    logic rst;

    ebi_tx_link_sched_if #(.CH_NUM(CH_NUM), .LINK_W(LINK_W), .MAX_BEATS(MAX_BEATS), .BEAT_W(BEAT_W)) bus ();

    ebi_tx_link_sched #(
        .CH_NUM(CH_NUM), .LINK_W(LINK_W), .MAX_BEATS(MAX_BEATS), .BEAT_W(BEAT_W),
        .CR_MASK(10'b11111_00000), .STARVE_LIMIT(8)
    ) dut (
        .m1_clk_i (m1_clk),
        .rst_i    (rst),
        .bus      (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          gq[$];
    beat_t       bq[$];
    int          gen[CH_NUM];
    logic [3:0]  tb_beats[CH_NUM];
    int          m_g;
    int          m_eff;
    beat_t       m_e;
    logic [CH_NUM-1:0] m_onehot;

    initial m1_clk = 1'b0;
    always #5 m1_clk = ~m1_clk;

    function automatic logic [LINK_W-1:0] beat_val(input int ch, input int b, input int g);
        return {8'(ch), 8'(g), 8'(b), 8'h5A};
    endfunction

    function automatic int eff_beats(input logic [3:0] raw);
        if (raw == 4'd0) return 1;
        if (int'(raw) > MAX_BEATS) return MAX_BEATS;
        return int'(raw);
    endfunction

    // Channel payloads follow a fixed pattern keyed on channel, beat and generation.
    always_comb begin
        bus.ch_data_i  = '0;
        bus.ch_beats_i = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            for (int b = 0; b < MAX_BEATS; b++) begin
                bus.ch_data_i[(c*MAX_BEATS + b)*LINK_W +: LINK_W] = beat_val(c, b, gen[c]);
            end
            bus.ch_beats_i[c*BEAT_W +: BEAT_W] = tb_beats[c];
        end
    end

    // Scoreboard: each grant pops the expected winner and queues its beats; each beat handshake pops one beat.
    always @(negedge m1_clk) begin
        if (!rst) begin
            if (bus.ch_ready_o != '0) begin
                total++;
                if (gq.size() == 0) begin
                    bad++;
                    $display("FAIL grant_unexpected: ch_ready=%h required none", bus.ch_ready_o);
                end else begin
                    m_g = gq.pop_front();
                    m_onehot = '0;
                    m_onehot[m_g] = 1'b1;
                    if (bus.ch_ready_o !== m_onehot) begin
                        bad++;
                        $display("FAIL grant_order: ch_ready=%h required %h", bus.ch_ready_o, m_onehot);
                    end
                    m_eff = eff_beats(tb_beats[m_g]);
                    for (int b = 0; b < m_eff; b++) begin
                        m_e.data = beat_val(m_g, b, gen[m_g]);
                        m_e.id   = 4'(m_g);
                        m_e.sof  = (b == 0);
                        m_e.eof  = (b == m_eff - 1);
                        bq.push_back(m_e);
                    end
                end
            end
            if (bus.link_valid_o && bus.link_ready_i) begin
                total++;
                if (bq.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: data=%h id=%0d required no beat", bus.link_data_o, bus.link_ch_id_o);
                end else begin
                    m_e = bq.pop_front();
                    if (bus.link_data_o !== m_e.data || bus.link_ch_id_o !== m_e.id ||
                        bus.link_sof_o !== m_e.sof || bus.link_eof_o !== m_e.eof) begin
                        bad++;
                        $display("FAIL beat: data=%h id=%0d sof=%b eof=%b required data=%h id=%0d sof=%b eof=%b",
                                 bus.link_data_o, bus.link_ch_id_o, bus.link_sof_o, bus.link_eof_o,
                                 m_e.data, m_e.id, m_e.sof, m_e.eof);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        bus.ch_valid_i   = '0;
        bus.link_ready_i = 1'b1;
        rst = 1'b1;
        #3;
        repeat (2) @(posedge m1_clk);
        #1 rst = 1'b0;
        bq.delete();
        gq.delete();
        for (int c = 0; c < CH_NUM; c++) begin
            gen[c]      = 0;
            tb_beats[c] = 4'd1;
        end
    endtask

    // Raise a request mask until one grant is seen, then drop it.
    task automatic send_one(input logic [CH_NUM-1:0] mask, output bit ok);
        ok = 1'b0;
        bus.ch_valid_i = mask;
        for (int i = 0; i < 40; i++) begin
            @(negedge m1_clk);
            if (bus.ch_ready_o != '0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge m1_clk);
        #1 bus.ch_valid_i = '0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge m1_clk);
            #2;
            if (bq.size() == 0 && gq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge m1_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ch_valid_i   = '0;
        bus.link_ready_i = 1'b1;
        for (int c = 0; c < CH_NUM; c++) begin
            gen[c]      = 0;
            tb_beats[c] = 4'd1;
        end
        @(negedge m1_clk);
        total++; if (bus.link_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", bus.link_valid_o); end
        total++; if (bus.ch_ready_o !== '0) begin bad++; $display("FAIL rst_ready: got %h required 0", bus.ch_ready_o); end
        total++; if (bus.link_data_o !== '0) begin bad++; $display("FAIL rst_data: got %h required 0", bus.link_data_o); end
        total++; if (bus.link_ch_id_o !== 4'd0) begin bad++; $display("FAIL rst_id: got %0d required 0", bus.link_ch_id_o); end
        total++; if (bus.link_sof_o !== 1'b0 || bus.link_eof_o !== 1'b0) begin
            bad++; $display("FAIL rst_sof_eof: got %b%b required 00", bus.link_sof_o, bus.link_eof_o);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        bit ok;
        apply_reset();
        tb_beats[0] = 4'd3;
        gq.push_back(0);
        bus.ch_valid_i = 10'h001;
        @(negedge m1_clk);
        total++; if (bus.link_valid_o !== 1'b0) begin bad++; $display("FAIL basic_idle: link_valid=%b required 0", bus.link_valid_o); end
        @(posedge m1_clk);
        #1 bus.ch_valid_i = '0;
        @(negedge m1_clk);
        total++; if (bus.link_valid_o !== 1'b1 || bus.link_sof_o !== 1'b1) begin
            bad++; $display("FAIL basic_latency: valid=%b sof=%b required 1 1", bus.link_valid_o, bus.link_sof_o);
        end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_drain: left %0d beats %0d grants required 0", bq.size(), gq.size()); end
    endtask

    task automatic test_priority();
        bit ok;
        apply_reset();
        gq.push_back(5);
        send_one(10'h021, ok);
        total++; if (!ok) begin bad++; $display("FAIL prio_grant: no grant seen required channel 5"); end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL prio_drain: left %0d beats required 0", bq.size()); end
        apply_reset();
        foreach (gq[i]) gq.delete(i);
        gq.push_back(5); gq.push_back(6); gq.push_back(7);
        gq.push_back(8); gq.push_back(9); gq.push_back(5);
        bus.ch_valid_i = 10'h3E0;
        repeat (6) @(posedge m1_clk);
        #1 bus.ch_valid_i = '0;
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_drain: left %0d grants required 0", gq.size()); end
    endtask

    task automatic test_starve();
        bit ok;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) gq.push_back(5);
            gq.push_back(0);
        end
        bus.ch_valid_i = 10'h021;
        repeat (18) @(posedge m1_clk);
        #1 bus.ch_valid_i = '0;
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL starve_drain: left %0d grants required 0", gq.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        apply_reset();
        tb_beats[0] = 4'd2;
        gq.push_back(0);
        gq.push_back(0);
        bus.ch_valid_i = 10'h001;
        @(posedge m1_clk);
        #1 gen[0] = 1;
        @(posedge m1_clk);
        #1 bus.link_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge m1_clk);
            total++;
            if (bus.link_valid_o !== 1'b1 || bus.link_data_o !== beat_val(0, 1, 0) ||
                bus.link_eof_o !== 1'b1 || bus.link_ch_id_o !== 4'd0 || bus.ch_ready_o !== '0) begin
                bad++;
                $display("FAIL stall_hold: valid=%b data=%h eof=%b id=%0d rdy=%h required 1 %h 1 0 0",
                         bus.link_valid_o, bus.link_data_o, bus.link_eof_o, bus.link_ch_id_o,
                         bus.ch_ready_o, beat_val(0, 1, 0));
            end
            @(posedge m1_clk);
        end
        #1 bus.link_ready_i = 1'b1;
        @(negedge m1_clk);
        total++; if (bus.ch_ready_o !== 10'h001) begin bad++; $display("FAIL b2b_accept: rdy=%h required 001", bus.ch_ready_o); end
        @(posedge m1_clk);
        #1 bus.ch_valid_i = '0;
        @(negedge m1_clk);
        total++; if (bus.link_valid_o !== 1'b1 || bus.link_sof_o !== 1'b1) begin
            bad++; $display("FAIL b2b_bubble: valid=%b sof=%b required 1 1", bus.link_valid_o, bus.link_sof_o);
        end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_drain: left %0d beats required 0", bq.size()); end
    endtask

    task automatic test_clamp();
        bit ok;
        apply_reset();
        tb_beats[0] = 4'd0;
        gq.push_back(0);
        send_one(10'h001, ok);
        @(negedge m1_clk);
        total++; if (bus.link_sof_o !== 1'b1 || bus.link_eof_o !== 1'b1) begin
            bad++; $display("FAIL zero_beats: sof=%b eof=%b required 1 1", bus.link_sof_o, bus.link_eof_o);
        end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_drain: left %0d beats required 0", bq.size()); end
        tb_beats[0] = 4'd15;
        gq.push_back(0);
        send_one(10'h001, ok);
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL clamp_drain: left %0d beats required 0", bq.size()); end
    endtask

    task automatic test_async_reset();
        bit ok;
        apply_reset();
        tb_beats[0] = 4'd4;
        gq.push_back(5);
        send_one(10'h020, ok);
        wait_drain(ok);
        gq.push_back(0);
        send_one(10'h001, ok);
        @(posedge m1_clk);
        @(posedge m1_clk);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.link_valid_o !== 1'b0 || bus.link_data_o !== '0) begin
            bad++; $display("FAIL async_rst: valid=%b data=%h required 0 0", bus.link_valid_o, bus.link_data_o);
        end
        bq.delete();
        gq.delete();
        @(posedge m1_clk);
        #1 rst = 1'b0;
        gq.push_back(5);
        send_one(10'h3E3, ok);
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_cr_ptr_drain: left %0d grants required 0", gq.size()); end
        gq.push_back(0);
        send_one(10'h003, ok);
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_nc_ptr_drain: left %0d grants required 0", gq.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_starve();
        test_back_to_back();
        test_clamp();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
